// File: rtl/regfile_pkg.sv
// Shared sizing defaults and constants for the load-scoreboarded register file.
// Latency: n/a (constants only); backpressure: n/a.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
    localparam int ZERO_ADDR      = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads; allocation beats a same-cycle clear.
// Latency: set/clear visible one cycle after the edge; backpressure: none, always accepts.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc,
    input  logic [ADDR_W-1:0]      alloc_addr,
    input  logic                   clr,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [2**ADDR_W-1:0]   busy
);

    localparam int REGS = 2 ** ADDR_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (ZERO_REG && i == ZERO_ADDR) begin
                    busy[i] <= 1'b0;
                end else if (alloc && alloc_addr == ADDR_W'(i)) begin
                    // a fresh load is outstanding even if the old one returns now
                    busy[i] <= 1'b1;
                end else if (clr && clr_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with ALU and load writeback ports, write-to-read bypass and load busy bits.
// Latency: writes land at the next edge, reads bypass same-cycle; load port stalls only on an ALU same-address write.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] add_Rs,
    output logic [DATA_W-1:0] out_Rs,
    output logic              busy_Rs,
    input  logic [ADDR_W-1:0] add_Rt,
    output logic [DATA_W-1:0] out_Rt,
    output logic              busy_Rt,
    input  logic              regwr,
    input  logic [ADDR_W-1:0] add_Rd,
    input  logic [DATA_W-1:0] data_wr,
    input  logic              ld_alloc,
    input  logic [ADDR_W-1:0] ld_alloc_addr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] regs [REGS];
    logic [REGS-1:0]   busy;
    logic              alu_fire;
    logic              ld_fire;

    assign alu_fire = regwr && !(ZERO_REG && add_Rd == ZADDR);
    assign ld_ready = !(alu_fire && add_Rd == ld_addr);
    assign ld_fire  = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (ZERO_REG && i == ZERO_ADDR) begin
                    regs[i] <= '0;
                end else if (alu_fire && add_Rd == ADDR_W'(i)) begin
                    regs[i] <= data_wr;
                end else if (ld_fire && ld_addr == ADDR_W'(i)) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (ld_alloc),
        .alloc_addr (ld_alloc_addr),
        .clr        (ld_fire),
        .clr_addr   (ld_addr),
        .busy       (busy)
    );

    assign out_Rs = (ZERO_REG && add_Rs == ZADDR)  ? '0      :
                    (alu_fire && add_Rd == add_Rs) ? data_wr :
                    (ld_fire && ld_addr == add_Rs) ? ld_data :
                                                     regs[add_Rs];

    assign out_Rt = (ZERO_REG && add_Rt == ZADDR)  ? '0      :
                    (alu_fire && add_Rd == add_Rt) ? data_wr :
                    (ld_fire && ld_addr == add_Rt) ? ld_data :
                                                     regs[add_Rt];

    // a load returning this cycle already supplies its data through the bypass
    assign busy_Rs = busy[add_Rs] && !(ld_fire && ld_addr == add_Rs);
    assign busy_Rt = busy[add_Rt] && !(ld_fire && ld_addr == add_Rt);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of the default register file and a wide, ordinary-R0 variant.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  add_Rs, add_Rt, add_Rd, ld_alloc_addr, ld_addr;
    logic [15:0] out_Rs, out_Rt, data_wr, ld_data;
    logic        busy_Rs, busy_Rt, regwr, ld_alloc, ld_valid, ld_ready;

    logic [4:0]  w_add_Rs, w_add_Rt, w_add_Rd, w_ld_alloc_addr, w_ld_addr;
    logic [31:0] w_out_Rs, w_out_Rt, w_data_wr, w_ld_data;
    logic        w_busy_Rs, w_busy_Rt, w_regwr, w_ld_alloc, w_ld_valid, w_ld_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .add_Rs(add_Rs), .out_Rs(out_Rs), .busy_Rs(busy_Rs),
        .add_Rt(add_Rt), .out_Rt(out_Rt), .busy_Rt(busy_Rt),
        .regwr(regwr), .add_Rd(add_Rd), .data_wr(data_wr),
        .ld_alloc(ld_alloc), .ld_alloc_addr(ld_alloc_addr),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .add_Rs(w_add_Rs), .out_Rs(w_out_Rs), .busy_Rs(w_busy_Rs),
        .add_Rt(w_add_Rt), .out_Rt(w_out_Rt), .busy_Rt(w_busy_Rt),
        .regwr(w_regwr), .add_Rd(w_add_Rd), .data_wr(w_data_wr),
        .ld_alloc(w_ld_alloc), .ld_alloc_addr(w_ld_alloc_addr),
        .ld_valid(w_ld_valid), .ld_ready(w_ld_ready),
        .ld_addr(w_ld_addr), .ld_data(w_ld_data)
    );

    task automatic idle_inputs();
        regwr = 0; add_Rd = 0; data_wr = 0;
        ld_alloc = 0; ld_alloc_addr = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        w_regwr = 0; w_add_Rd = 0; w_data_wr = 0;
        w_ld_alloc = 0; w_ld_alloc_addr = 0;
        w_ld_valid = 0; w_ld_addr = 0; w_ld_data = 0;
        w_add_Rs = 0; w_add_Rt = 0;
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        add_Rs = 5; add_Rt = 0;
        #2;
        checks++;
        if (out_Rs !== 16'h0000 || busy_Rs !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state out_Rs=%h busy=%b rdy=%b expected 0000 0 1", out_Rs, busy_Rs, ld_ready);
        end
        next_cycle();
        rst_n = 1;
        regwr = 1; add_Rd = 5; data_wr = 16'h1234;
        ld_alloc = 1; ld_alloc_addr = 5;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (out_Rs !== 16'h1234 || busy_Rs !== 1'b1) begin
            errors++;
            $display("FAIL r5_before_reset got %h busy %b expected 1234 1", out_Rs, busy_Rs);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_Rs !== 16'h0000 || busy_Rs !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h busy %b expected 0000 0", out_Rs, busy_Rs);
        end
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_bypass_zero();
        regwr = 1; add_Rd = 3; data_wr = 16'hBEEF; add_Rs = 3;
        #1;
        checks++;
        if (out_Rs !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h expected beef", out_Rs);
        end
        next_cycle();
        regwr = 1; add_Rd = 0; data_wr = 16'hFFFF; add_Rs = 0; add_Rt = 3;
        #1;
        checks++;
        if (out_Rs !== 16'h0000 || out_Rt !== 16'hBEEF) begin
            errors++;
            $display("FAIL r0_write_bypass got Rs=%h Rt=%h expected 0000 beef", out_Rs, out_Rt);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (out_Rs !== 16'h0000) begin
            errors++;
            $display("FAIL r0_after_write got %h expected 0000", out_Rs);
        end
    endtask

    task automatic test_load_lifecycle();
        ld_alloc = 1; ld_alloc_addr = 7; add_Rt = 7;
        next_cycle();
        ld_alloc = 0;
        #1;
        checks++;
        if (busy_Rt !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_set got %b expected 1", busy_Rt);
        end
        repeat (2) next_cycle();
        ld_valid = 1; ld_addr = 7; ld_data = 16'hA5A5;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || busy_Rt !== 1'b0 || out_Rt !== 16'hA5A5) begin
            errors++;
            $display("FAIL load_return rdy=%b busy=%b data=%h expected 1 0 a5a5", ld_ready, busy_Rt, out_Rt);
        end
        next_cycle();
        ld_valid = 0;
        #1;
        checks++;
        if (busy_Rt !== 1'b0 || out_Rt !== 16'hA5A5) begin
            errors++;
            $display("FAIL load_after busy=%b data=%h expected 0 a5a5", busy_Rt, out_Rt);
        end
    endtask

    task automatic test_conflict();
        regwr = 1; add_Rd = 9; data_wr = 16'h1111;
        ld_valid = 1; ld_addr = 9; ld_data = 16'h2222; add_Rs = 9;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || out_Rs !== 16'h1111) begin
            errors++;
            $display("FAIL conflict_stall rdy=%b data=%h expected 0 1111", ld_ready, out_Rs);
        end
        next_cycle();
        regwr = 0;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || out_Rs !== 16'h2222) begin
            errors++;
            $display("FAIL conflict_retry rdy=%b data=%h expected 1 2222", ld_ready, out_Rs);
        end
        next_cycle();
        ld_valid = 0;
        #1;
        checks++;
        if (out_Rs !== 16'h2222) begin
            errors++;
            $display("FAIL conflict_commit got %h expected 2222", out_Rs);
        end
    endtask

    task automatic test_dual_write();
        regwr = 1; add_Rd = 1; data_wr = 16'h0101;
        ld_valid = 1; ld_addr = 2; ld_data = 16'h0202;
        add_Rs = 1; add_Rt = 2;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL dual_ready got %b expected 1", ld_ready);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (out_Rs !== 16'h0101 || out_Rt !== 16'h0202) begin
            errors++;
            $display("FAIL dual_commit got %h %h expected 0101 0202", out_Rs, out_Rt);
        end
    endtask

    task automatic test_set_wins();
        ld_alloc = 1; ld_alloc_addr = 4; add_Rs = 4;
        next_cycle();
        ld_valid = 1; ld_addr = 4; ld_data = 16'h0042;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || out_Rs !== 16'h0042 || busy_Rs !== 1'b0) begin
            errors++;
            $display("FAIL setwins_cycle rdy=%b data=%h busy=%b expected 1 0042 0", ld_ready, out_Rs, busy_Rs);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (out_Rs !== 16'h0042 || busy_Rs !== 1'b1) begin
            errors++;
            $display("FAIL setwins_after data=%h busy=%b expected 0042 1", out_Rs, busy_Rs);
        end
        ld_valid = 1; ld_addr = 4; ld_data = 16'h0042;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_zero_load();
        ld_alloc = 1; ld_alloc_addr = 0; add_Rs = 0;
        next_cycle();
        ld_alloc = 0;
        ld_valid = 1; ld_addr = 0; ld_data = 16'h7777;
        #1;
        checks++;
        if (busy_Rs !== 1'b0 || ld_ready !== 1'b1 || out_Rs !== 16'h0000) begin
            errors++;
            $display("FAIL zero_load busy=%b rdy=%b data=%h expected 0 1 0000", busy_Rs, ld_ready, out_Rs);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (out_Rs !== 16'h0000) begin
            errors++;
            $display("FAIL zero_load_after got %h expected 0000", out_Rs);
        end
    endtask

    task automatic test_wide();
        w_regwr = 1; w_add_Rd = 31; w_data_wr = 32'hDEADBEEF;
        next_cycle();
        w_add_Rd = 0; w_data_wr = 32'h5;
        next_cycle();
        idle_inputs();
        w_add_Rs = 31; w_add_Rt = 0;
        #1;
        checks++;
        if (w_out_Rs !== 32'hDEADBEEF || w_out_Rt !== 32'h5) begin
            errors++;
            $display("FAIL wide_readback got %h %h expected deadbeef 00000005", w_out_Rs, w_out_Rt);
        end
        w_ld_alloc = 1; w_ld_alloc_addr = 0;
        next_cycle();
        w_ld_alloc = 0;
        #1;
        checks++;
        if (w_busy_Rt !== 1'b1) begin
            errors++;
            $display("FAIL wide_r0_busy got %b expected 1", w_busy_Rt);
        end
    endtask

    initial begin
        add_Rs = 0; add_Rt = 0;
        test_reset();
        test_bypass_zero();
        test_load_lifecycle();
        test_conflict();
        test_dual_write();
        test_set_wins();
        test_zero_load();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with integrated load scoreboard, the next generation of the 16x16 processor register file. It adds:
- width and depth parameters;
- a second write port for multi-cycle load writeback, with a valid/ready handshake;
- same-cycle write-to-read bypass;
- per-register busy bits so issue logic can stall on outstanding loads.

It sits between decode (read ports), the ALU writeback stage and the load/store unit.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width; register count is 2**ADDR_W
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes, allocations and busy ignored); 0 = register 0 is ordinary

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
add_Rs  in  ADDR_W  read port S address
out_Rs  out  DATA_W  read port S data (combinational, bypassed)
busy_Rs  out  1  register at add_Rs has a load outstanding
add_Rt  in  ADDR_W  read port T address
out_Rt  out  DATA_W  read port T data (combinational, bypassed)
busy_Rt  out  1  register at add_Rt has a load outstanding
regwr  in  1  ALU write enable
add_Rd  in  ADDR_W  ALU write address
data_wr  in  DATA_W  ALU write data
ld_alloc  in  1  mark ld_alloc_addr busy (load issued)
ld_alloc_addr  in  ADDR_W  destination of issued load
ld_valid  in  1  load writeback valid
ld_ready  out  1  load writeback accepted this cycle
ld_addr  in  ADDR_W  load writeback address
ld_data  in  DATA_W  load writeback data

Behaviour:
Reset:
- rst_n low asynchronously clears all registers to 0 and all busy bits to 0, independent of clk.
- Reset held over a rising edge blocks all writes and allocations.
- A load in flight across reset is lost; a later ld_valid for it is accepted and written normally. Busy is not set again, because the busy state was cleared.

Fire conditions (combinational):
- alu_fire = regwr and not (ZERO_REG and add_Rd==0).
- ld_fire = ld_valid and ld_ready.
- ld_ready = not (alu_fire and add_Rd==ld_addr). The ALU port wins a same-address conflict. The load source must hold ld_valid, ld_addr and ld_data stable until ld_ready.
- With ZERO_REG set, a load writeback to register 0 still handshakes (ld_ready high, unless the ALU conflict rule applies) but does not write.

Writes:
- Writes are committed at the rising edge.
- Two fires to different addresses in the same cycle both commit.
- Latency: one write is visible in the array at the next cycle.

Reads (combinational, priority high to low):
1. ZERO_REG and address 0 -> 0.
2. alu_fire and add_Rd == read address -> data_wr.
3. ld_fire and ld_addr == read address -> ld_data.
4. Otherwise -> array contents.

The bypass gives zero-cycle write-to-read visibility.

Scoreboard (one busy bit per register):
- ld_alloc at the edge sets busy[ld_alloc_addr]; ignored for register 0 when ZERO_REG is set.
- ld_fire at the edge clears busy[ld_addr].
- Alloc and fire to the same address in the same cycle: set wins, because a new load is outstanding.
- Alloc to an already-busy register leaves it set.
- ALU writes never change busy bits. WAW ordering is the issue logic's responsibility.
- busy_Rs = busy[add_Rs] and not (ld_fire and ld_addr==add_Rs). busy_Rt is the same for add_Rt. A register whose load is returning this cycle therefore reads as not busy, with the bypassed data.

No simulation $display in synthesizable RTL.

Decomposition:
Shared package regfile_pkg holds:
- default DATA_W and ADDR_W;
- localparam NUM_REGS = 2**ADDR_W;
- ZERO_ADDR constant.

Sub-module regfile_scoreboard (clk, rst_n, alloc, alloc_addr, clr, clr_addr, busy vector) holds the busy-bit vector and its set-wins rule. Data array, bypass muxes and the handshake live in regfile_sb.

Test Plan:
1. Reset then read: pulse rst_n low mid-cycle after writing R5=0x1234 -> out_Rs for add_Rs=5 is 0x0000 immediately, busy_Rs=0, without waiting for a clock edge.
2. Bypass and zero register: regwr=1, add_Rd=3, data_wr=0xBEEF, add_Rs=3 in the same cycle -> out_Rs=0xBEEF before the edge. Write 0xFFFF to R0 -> out_Rs for R0 stays 0x0000.
3. Load lifecycle: ld_alloc R7 -> busy_Rt=1 for add_Rt=7 next cycle. Three cycles later ld_valid with ld_addr=7, ld_data=0xA5A5 -> ld_ready=1, busy_Rt=0 and out_Rt=0xA5A5 that cycle; busy stays 0 afterwards.
4. Port conflict: regwr to R9 (0x1111) and ld_valid to R9 (0x2222) in the same cycle -> ld_ready=0, R9=0x1111. Next cycle with regwr=0 -> ld_ready=1, R9=0x2222.
5. Set-wins: R4 busy; ld_alloc R4 and ld_fire R4 (0x0042) in the same cycle -> R4=0x0042, busy[4] remains 1.
6. Parameter sweep: DATA_W=32, ADDR_W=5, ZERO_REG=0 -> write 0xDEADBEEF to R31 and 0x5 to R0, read both back exactly.
